// File: rtl/wb_trace_fifo_if.sv
// Writeback trace bus: the writeback strobe going into the trace FIFO and the
// FWFT head/status coming out of it.
interface wb_trace_fifo_if #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wb_en;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_reg;
    logic [31:0]      out_data;
    logic [SEQ_W-1:0] out_seq;
    logic [CNT_W-1:0] count;
    logic             full;
    logic [7:0]       overflow_cnt;

    modport master (
        output wb_en, wb_reg, wb_data, out_ready,
        input  out_valid, out_reg, out_data, out_seq, count, full, overflow_cnt
    );

    modport slave (
        input  wb_en, wb_reg, wb_data, out_ready,
        output out_valid, out_reg, out_data, out_seq, count, full, overflow_cnt
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// Trace FIFO for register writebacks: tags each non-r0 write with a sequence
// number and presents the oldest entry first-word-fall-through.
module wb_trace_fifo #(
    parameter int DEPTH = 8,   // power of two, >= 2
    parameter int SEQ_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    wb_trace_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 5 + 32 + SEQ_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [SEQ_W-1:0] seq_reg;
    logic [7:0]       ovf_reg;

    logic             qual;
    logic             pop;
    logic             push;
    logic             drop;
    logic             not_empty;
    logic             is_full;
    logic [ENT_W-1:0] head_entry;

    assign not_empty = (count_reg != '0);
    assign is_full   = (count_reg == DEPTH_C);
    assign qual      = bus.wb_en && (bus.wb_reg != 5'd0);
    assign pop       = not_empty && bus.out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push      = qual && (!is_full || pop);
    assign drop      = qual && is_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            seq_reg    <= '0;
            ovf_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Dropped events still consume a tag so gaps in out_seq reveal losses.
            if (qual) seq_reg <= seq_reg + 1'b1;
            if (drop && (ovf_reg != 8'hFF)) ovf_reg <= ovf_reg + 1'b1;
        end
    end

    // Storage is unreset; the masked outputs below keep stale entries hidden.
    always_ff @(posedge clk) begin
        if (push && rst_n) mem_reg[wr_ptr_reg] <= {bus.wb_reg, bus.wb_data, seq_reg};
    end

    assign head_entry       = mem_reg[rd_ptr_reg];
    assign bus.out_valid    = not_empty;
    assign bus.out_reg      = not_empty ? head_entry[ENT_W-1 -: 5] : 5'd0;
    assign bus.out_data     = not_empty ? head_entry[SEQ_W +: 32] : 32'd0;
    assign bus.out_seq      = not_empty ? head_entry[SEQ_W-1:0] : '0;
    assign bus.count        = count_reg;
    assign bus.full         = is_full;
    assign bus.overflow_cnt = ovf_reg;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_trace_fifo;
    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;

    typedef struct {
        logic [4:0]       r;
        logic [31:0]      d;
        logic [SEQ_W-1:0] s;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_trace_fifo_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

    wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of entries, a tag counter, a drop counter.
    ent_t             mq[$];
    logic [SEQ_W-1:0] m_seq = '0;
    int               m_ovf = 0;
    bit               m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_seq  = '0;
            m_ovf  = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            bit   do_pop;
            bit   qual;
            ent_t e;
            do_pop = (mq.size() != 0) && bus.out_ready;
            qual   = bus.wb_en && (bus.wb_reg != 5'd0);
            if (do_pop) begin
                e = mq.pop_front();
                $display("[TB] pop reg=%0d data=%08h seq=%0d", e.r, e.d, e.s);
            end
            if (qual) begin
                if (mq.size() < DEPTH) begin
                    e.r = bus.wb_reg;
                    e.d = bus.wb_data;
                    e.s = m_seq;
                    mq.push_back(e);
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
                m_seq = m_seq + 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live && rst_n) begin
            bit   v;
            ent_t h;
            v = (mq.size() != 0);
            if (v) h = mq[0];
            else begin
                h.r = '0; h.d = '0; h.s = '0;
            end
            check("out_valid", 64'(bus.out_valid), 64'(v));
            check("out_reg",   64'(bus.out_reg),   64'(h.r));
            check("out_data",  64'(bus.out_data),  64'(h.d));
            check("out_seq",   64'(bus.out_seq),   64'(h.s));
            check("count",     64'(bus.count),     64'(mq.size()));
            check("full",      64'(bus.full),      64'(mq.size() == DEPTH));
            check("overflow",  64'(bus.overflow_cnt), 64'(m_ovf));
        end
    end

    // Drive inputs (we sit just after a negedge), let one rising edge pass,
    // and return at the following negedge with outputs settled.
    task automatic step(input logic en, input logic [4:0] r, input logic [31:0] d, input logic rdy);
        bus.wb_en     = en;
        bus.wb_reg    = r;
        bus.wb_data   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 5'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst count", 64'(bus.count), 64'd0);
        check("rst valid", 64'(bus.out_valid), 64'd0);
        check("rst full", 64'(bus.full), 64'd0);
        check("rst ovf", 64'(bus.overflow_cnt), 64'd0);
        check("rst data", 64'(bus.out_data), 64'd0);

        // Basic single event
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        check("basic valid", 64'(bus.out_valid), 64'd1);
        check("basic reg", 64'(bus.out_reg), 64'd5);
        check("basic data", 64'(bus.out_data), 64'hDEADBEEF);
        check("basic seq", 64'(bus.out_seq), 64'd0);
        check("basic count", 64'(bus.count), 64'd1);

        // Register-0 writes are invisible and consume no tag
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 32'h1234_0000 + 32'(i), 1'b0);
        check("r0 count", 64'(bus.count), 64'd0);
        step(1'b1, 5'd7, 32'h0000_0077, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0);
        check("r0 count1", 64'(bus.count), 64'd1);
        check("r0 seq", 64'(bus.out_seq), 64'd0);
        check("r0 reg", 64'(bus.out_reg), 64'd7);

        // Overflow then drain
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, 5'(i), 32'(i), 1'b0);
        check("ovf count", 64'(bus.count), 64'd8);
        check("ovf full", 64'(bus.full), 64'd1);
        check("ovf cnt", 64'(bus.overflow_cnt), 64'd2);
        for (int k = 1; k <= 8; k++) begin
            check("drain data", 64'(bus.out_data), 64'(k));
            check("drain seq", 64'(bus.out_seq), 64'(k - 1));
            step(1'b0, 5'd0, 32'd0, 1'b1);
        end
        check("drain empty", 64'(bus.out_valid), 64'd0);

        // Full plus simultaneous pop: tags 10..17 fill, the extra event gets 18
        for (int i = 0; i < 8; i++) step(1'b1, 5'd3, 32'h100 + 32'(i), 1'b0);
        check("fp full", 64'(bus.full), 64'd1);
        step(1'b1, 5'd9, 32'h99, 1'b1);
        check("fp count", 64'(bus.count), 64'd8);
        check("fp ovf", 64'(bus.overflow_cnt), 64'd2);
        for (int i = 0; i < 7; i++) step(1'b0, 5'd0, 32'd0, 1'b1);
        check("fp last data", 64'(bus.out_data), 64'h99);
        check("fp last seq", 64'(bus.out_seq), 64'd18);
        step(1'b0, 5'd0, 32'd0, 1'b1);

        // Streaming
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 5'((i % 31) + 1), $urandom, 1'b1);
            check("stream count<=1", 64'(bus.count <= 1), 64'd1);
            check("stream seq", 64'(bus.out_seq), 64'(i));
        end
        check("stream ovf", 64'(bus.overflow_cnt), 64'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1);

        // Reset mid-stream, with a push and pop offered on the reset edge
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 5'd4, 32'(i), 1'b0);
        check("pre-rst count", 64'(bus.count), 64'd5);
        rst_n = 1'b0;
        step(1'b1, 5'd6, 32'hAAAA, 1'b1);
        rst_n = 1'b1;
        check("midrst count", 64'(bus.count), 64'd0);
        check("midrst valid", 64'(bus.out_valid), 64'd0);
        check("midrst ovf", 64'(bus.overflow_cnt), 64'd0);
        step(1'b1, 5'd3, 32'h55, 1'b0);
        check("midrst seq", 64'(bus.out_seq), 64'd0);

        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < 270; i++) step(1'b1, 5'd1, 32'(i), 1'b0);
        check("ovf sat", 64'(bus.overflow_cnt), 64'd255);

        // Randomized traffic with phases of biased readiness and rare resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            logic en;
            int   bias;
            bias = ((i / 100) % 3 == 0) ? 20 : ((i / 100) % 3 == 1) ? 80 : 50;
            rdy = ($urandom_range(99) < 32'(bias));
            en  = ($urandom_range(99) < 70);
            rst_n = ($urandom_range(199) != 0);
            step(en, 5'($urandom_range(31)), $urandom, rdy);
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, at least 2.
REQ-002 Parameter SEQ_W, default 16, sequence-tag width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 wb_en  input  1  writeback-stage RegWrite strobe.
REQ-006 wb_reg  input  5  writeback destination register.
REQ-007 wb_data  input  32  writeback value (the data driven after the WB select mux).
REQ-008 out_valid  output  1  a head entry is presented.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 out_reg  output  5  head entry register number.
REQ-011 out_data  output  32  head entry value.
REQ-012 out_seq  output  SEQ_W  head entry sequence tag.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 full  output  1  count equals DEPTH.
REQ-015 overflow_cnt  output  8  number of dropped events.

Function
REQ-016 A qualifying event SHALL be a cycle with wb_en=1 and wb_reg!=0; writes to register 0 SHALL be ignored entirely, with no tag consumed.
REQ-017 The block SHALL keep an internal SEQ_W-bit tag counter that increments by 1 on every qualifying event, whether stored or dropped, and wraps from all-ones to 0.
REQ-018 A stored entry SHALL carry {wb_reg, wb_data, tag value before the increment}, so the first event after reset carries tag 0.
REQ-019 Push SHALL occur on a qualifying event when count<DEPTH, or when count=DEPTH and a pop occurs in the same cycle.
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-021 A qualifying event with count=DEPTH and no same-cycle pop SHALL be dropped; overflow_cnt SHALL increment and saturate at 255.
REQ-022 Output SHALL be first-word-fall-through: out_valid = (count!=0); out_reg/out_data/out_seq SHALL reflect the oldest entry combinationally from registered storage.
REQ-023 Latency: an event pushed at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N, with no bypass in the same cycle.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, and entry order SHALL be preserved.
REQ-025 count SHALL change only by +1 (push only), -1 (pop only) or 0; full SHALL equal (count==DEPTH).
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 When out_valid=0, out_reg, out_data and out_seq SHALL be 0.
REQ-028 out_ready asserted while empty SHALL have no effect.
REQ-029 Inputs wb_reg and wb_data SHALL be sampled only on the edge where the push occurs.

Reset
REQ-030 When rst_n=0 at a rising edge: pointers, count, tag counter and overflow_cnt SHALL be 0; out_valid=0; full=0; out_reg, out_data and out_seq SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all stored entries, and any push or pop in that cycle SHALL be ignored.
REQ-032 Storage array contents need no reset, but they SHALL NOT be visible at the outputs while empty.

Verification
REQ-033 Basic: after reset, wb_en=1, wb_reg=5, wb_data=0xDEADBEEF for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_reg=5, out_data=0xDEADBEEF, out_seq=0, count=1.
REQ-034 Register-0 filter: wb_en=1 with wb_reg=0 for 3 cycles, then wb_reg=7 -> only one entry stored, with out_seq=0 and count=1.
REQ-035 Overflow: out_ready=0, 10 qualifying events with data 1..10 -> count=8, full=1, overflow_cnt=2; then drain with out_ready=1 -> data 1..8 with seq 0..7, after which out_valid=0.
REQ-036 Full plus simultaneous pop: with FIFO full, assert out_ready=1 and a qualifying event in the same cycle -> count stays 8, overflow_cnt unchanged, new entry appears last with the next tag.
REQ-037 Streaming: out_ready=1 permanently, events every cycle for 20 cycles -> count never exceeds 1, outputs in order with out_seq 0..19, overflow_cnt=0.
REQ-038 Reset mid-stream: FIFO holding 5 entries, rst_n=0 for one edge -> count=0, out_valid=0, overflow_cnt=0; the next event carries out_seq=0.
